// File: rtl/sd_dac9.sv
// sd_dac9: first-order sigma-delta DAC for 9-bit signed control samples.
// Runs at 64x the 60 kHz sample rate. Incoming samples are double-buffered
// and promoted to the active value only at oversampling-frame boundaries.
// The 1-bit output drives an external RC reconstruction filter.
module sd_dac9 #(
    parameter int W        = 9,
    parameter int OSR_LOG2 = 6
) (
    input  logic                clk3d84MHz,
    input  logic                rst_n,
    input  logic                en,
    input  logic signed [W-1:0] in,
    input  logic                in_valid,
    input  logic                ovr_clr,
    output logic                out,
    output logic                frame_sync,
    output logic                overrun
);

    localparam int AW = W + 2;
    localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;
    localparam logic [OSR_LOG2-1:0] CNT_ONE  = OSR_LOG2'(1);
    localparam logic signed [AW-1:0] FB_POS  = AW'(2 ** (W - 1));
    localparam logic signed [AW-1:0] FB_NEG  = -FB_POS;

    logic [OSR_LOG2-1:0] cnt;
    logic signed [W-1:0]  pend;
    logic                 pend_full;
    logic signed [W-1:0]  act;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] act_ext;
    logic signed [AW-1:0] fb;
    logic signed [AW-1:0] acc_next;
    logic                 boundary;

    // Boundary detect, feedback selection and next integrator value.
    // The headroom of two extra bits keeps |acc| <= 512 without saturation.
    always_comb begin
        boundary = en && (cnt == CNT_LAST);
        act_ext  = {{(AW - W){act[W-1]}}, act};
        fb       = out ? FB_POS : FB_NEG;
        acc_next = acc + act_ext - fb;
    end

    // Frame counter, integrator, output bit and frame strobe; all idle at 0 while disabled.
    always_ff @(posedge clk3d84MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            acc        <= '0;
            out        <= 1'b0;
            frame_sync <= 1'b0;
        end else if (!en) begin
            cnt        <= '0;
            acc        <= '0;
            out        <= 1'b0;
            frame_sync <= 1'b0;
        end else begin
            cnt        <= cnt + CNT_ONE;
            acc        <= acc_next;
            out        <= ~acc_next[AW-1];
            frame_sync <= boundary;
        end
    end

    // Pending-sample buffer; it keeps accepting strobes even while disabled.
    // A strobe on the boundary refills the buffer right as its old content moves to act.
    always_ff @(posedge clk3d84MHz or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            pend_full <= 1'b0;
        end else begin
            if (in_valid) begin
                pend      <= in;
                pend_full <= 1'b1;
            end else if (boundary) begin
                pend_full <= 1'b0;
            end
        end
    end

    // Active sample: zero-order hold between boundaries, cleared while disabled.
    always_ff @(posedge clk3d84MHz or negedge rst_n) begin
        if (!rst_n) begin
            act <= '0;
        end else if (!en) begin
            act <= '0;
        end else if (boundary && pend_full) begin
            act <= pend;
        end
    end

    // Sticky overrun: an unused pending sample was replaced; a new set beats a clear.
    always_ff @(posedge clk3d84MHz or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (in_valid && pend_full && !boundary) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_dac9.sv
// tb_sd_dac9: directed bench for sd_dac9. Each stimulus step pushes the
// expected active value and frame density onto a queue; the entries are
// popped and compared at the frame_sync pulses the DUT produces.
module tb_sd_dac9;

    localparam int W = 9;

    logic                clk3d84MHz = 1'b0;
    logic                rst_n      = 1'b0;
    logic                en         = 1'b0;
    logic signed [W-1:0] in_s       = '0;
    logic                in_valid   = 1'b0;
    logic                ovr_clr    = 1'b0;
    logic                out;
    logic                frame_sync;
    logic                overrun;

    sd_dac9 #(.W(W), .OSR_LOG2(6)) dut (
        .clk3d84MHz (clk3d84MHz),
        .rst_n      (rst_n),
        .en         (en),
        .in         (in_s),
        .in_valid   (in_valid),
        .ovr_clr    (ovr_clr),
        .out        (out),
        .frame_sync (frame_sync),
        .overrun    (overrun)
    );

    always #130 clk3d84MHz = ~clk3d84MHz;

    typedef struct {
        string tag;
        int    act;
        int    lo;
        int    hi;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   ones_run   = 0;
    int   frame_ones = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_range(input string tag, input logic signed [31:0] obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One clock: sample 1 ns after the edge, tally ones per frame, bound the integrator.
    task automatic tick();
        @(posedge clk3d84MHz);
        #1;
        if (frame_sync === 1'b1) begin
            frame_ones = ones_run + ((out === 1'b1) ? 1 : 0);
            ones_run   = 0;
        end else begin
            ones_run += (out === 1'b1) ? 1 : 0;
        end
        check_range("acc_bound", dut.acc, -512, 511);
    endtask

    task automatic wait_fs(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_sync !== 1'b1 && n < 200);
        check({tag, "_fs"}, frame_sync, 1);
    endtask

    task automatic drive_sample(input int v);
        in_s     = W'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for the next frame boundary and compare it against the oldest expectation.
    task automatic next_frame();
        exp_t e;
        int   n;
        e = exp_q.pop_front();
        wait_fs(e.tag, n);
        check({e.tag, "_act"}, dut.act, e.act);
        check_range({e.tag, "_ones"}, frame_ones, e.lo, e.hi);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) tick();
        check("rst_out", out, 0);
        check("rst_fs", frame_sync, 0);
        check("rst_ovr", overrun, 0);
        check("rst_acc", dut.acc, 0);
        check("rst_pend_full", dut.pend_full, 0);

        // Idle modulation with act = 0
        rst_n = 1'b1;
        en    = 1'b1;
        wait_fs("idle1", n);
        check("first_fs_latency", n, 64);
        check("idle_act", dut.act, 0);
        wait_fs("idle2", n);
        check("fs_period", n, 64);
        check("idle_ones2", frame_ones, 32);
        wait_fs("idle3", n);
        check("idle_ones3", frame_ones, 32);

        // +128 strobed at cnt = 10
        repeat (10) tick();
        check("cnt_at_strobe", dut.cnt, 10);
        drive_sample(128);
        exp_q.push_back('{tag:"p128_load", act:128, lo:32, hi:32});
        exp_q.push_back('{tag:"p128_dens", act:128, lo:47, hi:49});
        next_frame();
        next_frame();
        check("p128_ovr", overrun, 0);

        // Full-scale negative, then near full-scale positive
        repeat (10) tick();
        drive_sample(-256);
        exp_q.push_back('{tag:"n256_load", act:-256, lo:47, hi:49});
        next_frame();
        repeat (10) tick();
        drive_sample(255);
        exp_q.push_back('{tag:"n256_dens", act:255, lo:0, hi:0});
        exp_q.push_back('{tag:"p255_dens", act:255, lo:63, hi:64});
        next_frame();
        next_frame();

        // Overwrite of a pending sample, clear, and set-beats-clear
        repeat (5) tick();
        drive_sample(50);
        repeat (14) tick();
        drive_sample(-50);
        check("ovr_set", overrun, 1);
        exp_q.push_back('{tag:"m50_load", act:-50, lo:63, hi:64});
        next_frame();
        check("ovr_sticky", overrun, 1);
        exp_q.push_back('{tag:"m50_dens", act:-50, lo:24, hi:27});
        next_frame();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        repeat (4) tick();
        drive_sample(7);
        repeat (2) tick();
        in_s     = W'(9);
        in_valid = 1'b1;
        ovr_clr  = 1'b1;
        tick();
        in_valid = 1'b0;
        ovr_clr  = 1'b0;
        check("ovr_set_wins", overrun, 1);
        exp_q.push_back('{tag:"p9_load", act:9, lo:24, hi:27});
        next_frame();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr2", overrun, 0);

        // Strobe exactly on the boundary while a sample is pending
        wait_fs("bnd_align", n);
        repeat (5) tick();
        drive_sample(10);
        repeat (57) tick();
        check("bnd_cnt", dut.cnt, 63);
        in_s     = W'(20);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bnd_fs", frame_sync, 1);
        check("bnd_act", dut.act, 10);
        check("bnd_pend", dut.pend, 20);
        check("bnd_pend_full", dut.pend_full, 1);
        check("bnd_ovr", overrun, 0);
        exp_q.push_back('{tag:"p20_load", act:20, lo:32, hi:35});
        next_frame();

        // Disable for 100 clocks mid-frame with a strobe while idle
        repeat (30) tick();
        en = 1'b0;
        tick();
        for (int i = 0; i < 99; i++) begin
            if (i == 40) begin
                in_s     = W'(100);
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check("en0_out", out, 0);
            check("en0_cnt", dut.cnt, 0);
            check("en0_fs", frame_sync, 0);
        end
        check("en0_act", dut.act, 0);
        en = 1'b1;
        wait_fs("en_rise", n);
        check("en_rise_latency", n, 64);
        check("en_rise_act", dut.act, 100);
        check("en_rise_ovr", overrun, 0);
        exp_q.push_back('{tag:"p100_dens", act:100, lo:43, hi:46});
        next_frame();

        // Asynchronous reset mid-frame discards the pending sample
        repeat (3) tick();
        drive_sample(77);
        drive_sample(78);
        check("pre_rst_ovr", overrun, 1);
        for (int k = 0; k < 4 && out !== 1'b1; k++) tick();
        check("pre_rst_out", out, 1);
        #50;
        rst_n = 1'b0;
        #1;
        check("arst_out", out, 0);
        check("arst_fs", frame_sync, 0);
        check("arst_ovr", overrun, 0);
        check("arst_pend_full", dut.pend_full, 0);
        check("arst_act", dut.act, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        check("rel_out", out, 0);
        wait_fs("rel", n);
        check("rel_latency", n, 64);
        check("rel_act", dut.act, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(260 * 50000);
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
